// File: rtl/reg_file_pkg.sv
// Shared constants, state type and elaboration helpers for the register bank.
package reg_file_pkg;

    // System clock and bus geometry
    localparam int unsigned SYS_CLOCK_MHZ  = 64;
    localparam int unsigned WB_ADDR_WIDTH  = 16;
    localparam logic [2:0]  WB_REG_PREFIX  = 3'b010;

    // Register bank defaults
    localparam int unsigned DEF_REG_COUNT        = 4;
    localparam int unsigned DEF_DATA_WIDTH       = 8;
    localparam int unsigned REG_CPU_RESET_MIN_NS = 1000;

    // Fixed register indices
    localparam int unsigned REG_CPU    = 0;
    localparam int unsigned REG_STATUS = 1;
    localparam int unsigned REG_CTRL0  = 2;

    // Bit positions inside REG_CPU
    localparam int unsigned CPU_READY_BIT = 0;
    localparam int unsigned CPU_RESET_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } reg_state_t;

    // Round a duration up to whole system clock cycles.
    function automatic int unsigned ns_to_cycles(input int unsigned ns);
        return (ns * SYS_CLOCK_MHZ + 999) / 1000;
    endfunction

    // Number of bits needed to hold value (at least 1).
    function automatic int unsigned bit_width(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((value >> w) != 0)) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Index width keeps one spare bit so indices past REG_COUNT stay decodable
    // instead of aliasing onto real registers.
    function automatic int unsigned reg_addr_width(input int unsigned count);
        return $clog2(count) + 1;
    endfunction

endpackage

// File: rtl/reg_file_reset_stretch.sv
// Stretches the CPU reset bit into a pulse of at least CYCLES clocks.
module reg_file_reset_stretch
    import reg_file_pkg::*;
#(
    parameter int unsigned CYCLES = 64
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic hold_i,
    output logic cpu_reset_o,
    output logic cpu_reset_d_o
);

    localparam int unsigned CNT_W = bit_width(CYCLES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cpu_reset_q;
    logic             cpu_reset_d;

    // Hold the counter loaded while the bit is set, then count down to zero and stop.
    always_comb begin
        cnt_d = cnt_q;
        if (hold_i) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        cpu_reset_d = hold_i | (cnt_d != '0);
    end

    // Counter and registered reset output; reset comes up asserted and fully loaded.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q       <= LOAD;
            cpu_reset_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign cpu_reset_o   = cpu_reset_q;
    assign cpu_reset_d_o = cpu_reset_d;

endmodule

// File: rtl/reg_file.sv
// Wishbone-slave control/status register bank: CPU reset/ready, synchronised
// status and general control registers exported to the fabric.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_COUNT    = DEF_REG_COUNT,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned RESET_MIN_NS = REG_CPU_RESET_MIN_NS,
    parameter int unsigned RESET_CYCLES = ns_to_cycles(RESET_MIN_NS),
    localparam int unsigned CTRL_N      = (REG_COUNT > 2) ? REG_COUNT - 2 : 1
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic [WB_ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [DATA_WIDTH-1:0]        wb_dat_i,
    output logic [DATA_WIDTH-1:0]        wb_dat_o,
    input  logic                         wb_we_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    output logic                         wb_ack_o,
    output logic                         wb_stall_o,
    input  logic [DATA_WIDTH-1:0]        status_i,
    output logic                         cpu_ready_o,
    output logic                         cpu_reset_o,
    output logic [CTRL_N*DATA_WIDTH-1:0] ctrl_o
);

    localparam int unsigned REG_ADDR_WIDTH = reg_addr_width(REG_COUNT);

    reg_state_t state_q;
    reg_state_t state_d;

    logic                                 sel_c;
    logic                                 accept_c;
    logic [REG_ADDR_WIDTH-1:0]            idx_c;
    logic [DATA_WIDTH-1:0]                rdata_c;

    logic                                 ack_q;
    logic                                 ack_d;
    logic                                 stall_q;
    logic                                 stall_d;
    logic [DATA_WIDTH-1:0]                dat_q;
    logic [DATA_WIDTH-1:0]                dat_d;

    logic                                 ready_q;
    logic                                 ready_d;
    logic                                 rst_bit_q;
    logic                                 rst_bit_d;
    logic                                 cpu_ready_q;
    logic                                 cpu_ready_d;
    logic                                 cpu_reset_d;

    logic [CTRL_N-1:0][DATA_WIDTH-1:0]    ctrl_q;
    logic [CTRL_N-1:0][DATA_WIDTH-1:0]    ctrl_d;

    logic [DATA_WIDTH-1:0]                status_s1_q;
    logic [DATA_WIDTH-1:0]                status_s2_q;

    logic                                 unused_adr_c;

    // Address bits between the prefix and the index are not decoded.
    assign unused_adr_c = ^wb_adr_i[WB_ADDR_WIDTH-4:REG_ADDR_WIDTH];

    // Slave select on the register prefix, and the register index it targets.
    assign sel_c = wb_cyc_i & wb_stb_i &
                   (wb_adr_i[WB_ADDR_WIDTH-1 -: 3] == WB_REG_PREFIX);
    assign idx_c = wb_adr_i[REG_ADDR_WIDTH-1:0];

    // Bus FSM next state: accept in IDLE, spend exactly one cycle in ACK.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_c) begin
                    accept_c = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ack_d   = (state_d == ACK);
        stall_d = (state_d == ACK);
    end

    // Read mux; REG_CPU reports the stretched reset, not the raw bit.
    always_comb begin
        rdata_c = '0;
        if (32'(idx_c) == REG_CPU) begin
            rdata_c[CPU_READY_BIT] = ready_q;
            rdata_c[CPU_RESET_BIT] = cpu_reset_o;
        end else if (32'(idx_c) == REG_STATUS) begin
            rdata_c = status_s2_q;
        end else begin
            for (int unsigned k = 0; k < CTRL_N; k++) begin
                if ((k + REG_CTRL0 < REG_COUNT) && (32'(idx_c) == k + REG_CTRL0)) begin
                    rdata_c = ctrl_q[k];
                end
            end
        end
    end

    // Register updates on accept: writes commit here, reads capture wb_dat_o.
    always_comb begin
        ready_d   = ready_q;
        rst_bit_d = rst_bit_q;
        ctrl_d    = ctrl_q;
        dat_d     = dat_q;
        if (accept_c) begin
            if (wb_we_i) begin
                if (32'(idx_c) == REG_CPU) begin
                    ready_d   = wb_dat_i[CPU_READY_BIT];
                    rst_bit_d = wb_dat_i[CPU_RESET_BIT];
                end
                for (int unsigned k = 0; k < CTRL_N; k++) begin
                    if ((k + REG_CTRL0 < REG_COUNT) && (32'(idx_c) == k + REG_CTRL0)) begin
                        ctrl_d[k] = wb_dat_i;
                    end
                end
            end else begin
                dat_d = rdata_c;
            end
        end
        cpu_ready_d = ready_d & ~cpu_reset_d;
    end

    // Bus FSM state and bus-side outputs.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            stall_q <= stall_d;
            dat_q   <= dat_d;
        end
    end

    // CPU control bits, gated ready and general control registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_q     <= 1'b0;
            rst_bit_q   <= 1'b1;
            cpu_ready_q <= 1'b0;
            ctrl_q      <= '0;
        end else begin
            ready_q     <= ready_d;
            rst_bit_q   <= rst_bit_d;
            cpu_ready_q <= cpu_ready_d;
            ctrl_q      <= ctrl_d;
        end
    end

    // Two-flop synchroniser for the asynchronous status inputs.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            status_s1_q <= '0;
            status_s2_q <= '0;
        end else begin
            status_s1_q <= status_i;
            status_s2_q <= status_s1_q;
        end
    end

    reg_file_reset_stretch #(
        .CYCLES        (RESET_CYCLES)
    ) u_reset_stretch (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
        .hold_i        (rst_bit_q),
        .cpu_reset_o   (cpu_reset_o),
        .cpu_reset_d_o (cpu_reset_d)
    );

    assign wb_ack_o    = ack_q;
    assign wb_stall_o  = stall_q;
    assign wb_dat_o    = dat_q;
    assign cpu_ready_o = cpu_ready_q;
    assign ctrl_o      = ctrl_q;

endmodule

// File: tb/tb_reg_file.sv
// Randomised scoreboard bench for reg_file against a cycle-counting reference model.
module tb_reg_file;
    import reg_file_pkg::*;

    localparam int DW   = 8;
    localparam int RC   = 4;
    localparam int RCYC = 64;

    logic                     clock_i   = 1'b0;
    logic                     reset_n_i = 1'b0;
    logic [WB_ADDR_WIDTH-1:0] wb_adr_i  = '0;
    logic [DW-1:0]            wb_dat_i  = '0;
    logic [DW-1:0]            wb_dat_o;
    logic                     wb_we_i   = 1'b0;
    logic                     wb_cyc_i  = 1'b0;
    logic                     wb_stb_i  = 1'b0;
    logic                     wb_ack_o;
    logic                     wb_stall_o;
    logic [DW-1:0]            status_i  = '0;
    logic                     cpu_ready_o;
    logic                     cpu_reset_o;
    logic [(RC-2)*DW-1:0]     ctrl_o;

    reg_file #(
        .REG_COUNT    (RC),
        .DATA_WIDTH   (DW),
        .RESET_MIN_NS (1000)
    ) dut (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_we_i     (wb_we_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_ack_o    (wb_ack_o),
        .wb_stall_o  (wb_stall_o),
        .status_i    (status_i),
        .cpu_ready_o (cpu_ready_o),
        .cpu_reset_o (cpu_reset_o),
        .ctrl_o      (ctrl_o)
    );

    always #5 clock_i = ~clock_i;

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Edge counter: value n means "state after the n-th rising edge".
    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    // Reference model: reset is the raw bit seen one edge late, or within
    // RCYC edges of the write that cleared it.
    logic       m_ready;
    logic       m_rbit;
    int         set_edge;
    int         clr_edge;
    logic [7:0] m_ctrl [2];
    logic [7:0] m_status;

    function automatic void model_reset();
        m_ready   = 1'b0;
        m_rbit    = 1'b1;
        set_edge  = -1000000;
        clr_edge  = -1000000;
        m_ctrl[0] = 8'h00;
        m_ctrl[1] = 8'h00;
        m_status  = 8'h00;
    endfunction

    function automatic logic exp_reset(input int n);
        return (m_rbit && (n > set_edge)) || (n < clr_edge + RCYC);
    endfunction

    function automatic logic [7:0] exp_rd(input int unsigned idx);
        case (idx)
            0:       return {6'b0, exp_reset(cyc), m_ready};
            1:       return m_status;
            2, 3:    return m_ctrl[idx-2];
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_write(input int unsigned idx, input logic [7:0] d, input int e);
        if (idx == 0) begin
            if (m_rbit && !d[1]) clr_edge = e;
            if (!m_rbit && d[1]) set_edge = e;
            m_rbit  = d[1];
            m_ready = d[0];
        end else if (idx == 2 || idx == 3) begin
            m_ctrl[idx-2] = d;
        end
    endfunction

    typedef struct packed {
        logic       rd;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;
    int   n_acks = 0;

    // Monitor: every ack pops one expected response.
    always @(negedge clock_i) begin
        if (reset_n_i && wb_ack_o) begin
            n_acks++;
            check("ack_with_stall", 32'(wb_stall_o), 32'd1);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'(wb_ack_o), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.rd) check("rdata", 32'(wb_dat_o), 32'(mon_e.d));
            end
        end
    end

    // Per-cycle check of CPU outputs and exported control registers.
    always @(negedge clock_i) begin
        if (reset_n_i) begin
            check("cpu_reset", 32'(cpu_reset_o), 32'(exp_reset(cyc)));
            check("cpu_ready", 32'(cpu_ready_o), 32'(m_ready & ~exp_reset(cyc)));
            check("ctrl_o", 32'(ctrl_o), 32'({m_ctrl[1], m_ctrl[0]}));
        end
    end

    task automatic xact(input int unsigned idx, input logic we, input logic [7:0] d);
        int   guard;
        int   acc;
        exp_t e;
        guard = 0;
        @(negedge clock_i);
        while (wb_stall_o && guard < 8) begin
            @(negedge clock_i);
            guard++;
        end
        if (wb_stall_o) begin
            check("stall_timeout", 32'(wb_stall_o), 32'd0);
            return;
        end
        e.rd = !we;
        e.d  = we ? 8'h00 : exp_rd(idx);
        sb_q.push_back(e);
        acc      = cyc + 1;
        wb_adr_i = {3'b010, {(WB_ADDR_WIDTH-6){1'b0}}, 3'(idx)};
        wb_dat_i = d;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge clock_i);
        if (we) model_write(idx, d, acc);
        @(negedge clock_i);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic do_reset();
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        reset_n_i = 1'b0;
        sb_q.delete();
        model_reset();
        repeat (3) @(negedge clock_i);
        reset_n_i = 1'b1;
        repeat (3) @(negedge clock_i);
        m_status = status_i;
    endtask

    task automatic set_status(input logic [7:0] v);
        status_i = v;
        repeat (3) @(negedge clock_i);
        m_status = v;
    endtask

    task automatic reset_len(input string name);
        int cnt;
        cnt = 0;
        while (cpu_reset_o && cnt < 200) begin
            cnt++;
            @(negedge clock_i);
        end
        check(name, 32'(cnt), 32'd64);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        model_reset();
        do_reset();

        // Reset state and first readback
        check("rst_reset_o", 32'(cpu_reset_o), 32'd1);
        check("rst_ready_o", 32'(cpu_ready_o), 32'd0);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_stall", 32'(wb_stall_o), 32'd0);
        check("rst_dat", 32'(wb_dat_o), 32'd0);
        xact(0, 1'b0, 8'h00);

        // Single clearing write gives a 64-cycle reset, ready follows
        xact(0, 1'b1, 8'h01);
        reset_len("tp2_reset_len");
        check("tp2_ready_rise", 32'(cpu_ready_o), 32'd1);
        xact(0, 1'b0, 8'h00);

        // Reload mid-countdown
        xact(0, 1'b1, 8'h03);
        xact(0, 1'b1, 8'h01);
        repeat (42) @(negedge clock_i);
        xact(0, 1'b1, 8'h03);
        xact(0, 1'b1, 8'h01);
        reset_len("tp3_reload_len");

        // Status synchroniser and read-only behaviour
        set_status(8'hA5);
        xact(1, 1'b0, 8'h00);
        xact(1, 1'b1, 8'hFF);
        xact(1, 1'b0, 8'h00);

        // Control registers and out-of-range index
        xact(3, 1'b1, 8'h5C);
        check("tp5_ctrl3", 32'(ctrl_o[15:8]), 32'h5C);
        xact(7, 1'b1, 8'hAB);
        xact(7, 1'b0, 8'h00);
        xact(2, 1'b0, 8'h00);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0) set_status(8'($urandom));
            else if (r == 1) repeat ($urandom_range(1, 80)) @(negedge clock_i);
            xact($urandom_range(0, 7), 1'($urandom), 8'($urandom));
        end

        // Wrong prefix never acks
        @(negedge clock_i);
        @(negedge clock_i);
        n0       = n_acks;
        wb_adr_i = {3'b000, {(WB_ADDR_WIDTH-6){1'b0}}, 3'd2};
        wb_dat_i = 8'h99;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        repeat (10) @(negedge clock_i);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        check("tp6_prefix_no_ack", 32'(n_acks - n0), 32'd0);

        // Reset asserted during ACK kills the ack at once
        @(negedge clock_i);
        wb_adr_i = {3'b010, {(WB_ADDR_WIDTH-6){1'b0}}, 3'd2};
        wb_dat_i = 8'h77;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge clock_i);
        #1;
        check("tp6_ack_before_rst", 32'(wb_ack_o), 32'd1);
        reset_n_i = 1'b0;
        sb_q.delete();
        model_reset();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        #1;
        check("tp6_ack_in_rst", 32'(wb_ack_o), 32'd0);
        check("tp6_stall_in_rst", 32'(wb_stall_o), 32'd0);
        check("tp6_reset_in_rst", 32'(cpu_reset_o), 32'd1);
        repeat (3) @(negedge clock_i);
        n0        = n_acks;
        reset_n_i = 1'b1;
        repeat (4) @(negedge clock_i);
        m_status = status_i;
        check("tp6_no_ack_after_rst", 32'(n_acks - n0), 32'd0);
        xact(0, 1'b0, 8'h00);
        xact(2, 1'b0, 8'h00);
        xact(1, 1'b0, 8'h00);

        repeat (4) @(negedge clock_i);
        check("pending_acks", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Parametrised Wishbone-slave control/status register bank. Generalises the fixed single-register CPU control map to REG_COUNT byte registers.
- Adds three behaviours:
  - a minimum-width CPU reset pulse timer;
  - a synchronised read-only status register;
  - general read/write control registers exported to the fabric.
- Sits on the system Wishbone bus under the register address prefix, beside the RAM and CPU bus slaves.

Parameters:
- REG_COUNT, 4: number of byte registers; minimum 2.
- DATA_WIDTH, 8: register and bus data width.
- RESET_MIN_NS, 1000: minimum CPU reset assertion, in ns.
- RESET_CYCLES, ns_to_cycles(RESET_MIN_NS): derived; 64 at 64 MHz.

Ports:
- clock_i  in  1  system clock, SYS_CLOCK_MHZ.
- reset_n_i  in  1  asynchronous, active-low reset.
- wb_adr_i  in  WB_ADDR_WIDTH  Wishbone address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- wb_stall_o  out  1  pipelined-mode stall.
- status_i  in  DATA_WIDTH  asynchronous status inputs, read at REG_STATUS.
- cpu_ready_o  out  1  CPU RDY.
- cpu_reset_o  out  1  CPU reset, active high.
- ctrl_o  out  (REG_COUNT-2)*DATA_WIDTH  flattened general registers; register k is at bits [(k-2)*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset:
  - Asynchronous, on reset_n_i low; all flops clear except as listed.
  - cpu_reset bit = 1, reset counter = RESET_CYCLES, cpu_reset_o = 1.
  - cpu_ready bit = 0.
  - ctrl_o = 0, wb_ack_o = 0, wb_stall_o = 0, wb_dat_o = 0, state = IDLE.
- Address decode:
  - Selected when cyc & stb & adr[WB_ADDR_WIDTH-1 -: 3] == WB_REG_PREFIX.
  - Index = adr[REG_ADDR_WIDTH-1:0].
  - Any other prefix: no ack, no side effects.
- FSM IDLE / ACK:
  - IDLE: on select, accept the request. A write updates the target at this edge. A read registers wb_dat_o at this edge. Go to ACK.
  - ACK: wb_ack_o = 1 and wb_stall_o = 1 for exactly one cycle, then return to IDLE.
  - Latency: ack one cycle after accept. Back-to-back accepts occur every 2 cycles.
  - cyc dropping in ACK does not cancel the ack; the write has already committed.
- Register map:
  - Index 0, REG_CPU: bit 0 is ready (R/W), bit 1 is reset (R/W). Other bits read 0.
  - Index 1, REG_STATUS: read-only, 2-flop synchroniser on status_i. Writes are acked and ignored.
  - Indices 2..REG_COUNT-1: R/W, drive ctrl_o.
  - Index >= REG_COUNT: ack, read 0, write ignored.
- Reset pulse timer:
  - While the reset bit = 1, the counter holds at RESET_CYCLES.
  - While the reset bit = 0 and counter != 0, the counter decrements by 1 per cycle.
  - cpu_reset_o = reset bit | (counter != 0), registered.
  - Net effect: a 1-cycle write pulse still yields at least RESET_CYCLES cycles of reset.
  - Re-writing 1 mid-countdown reloads the counter.
  - Counter width = bit_width(RESET_CYCLES). It saturates at 0 and never wraps.
- Ready gating: cpu_ready_o = ready bit & ~cpu_reset_o.
- REG_CPU readback returns the actual cpu_reset_o in bit 1, not the raw bit.
- Reset asserted mid-transaction: FSM returns to IDLE and no ack is issued.

Decomposition:
- common_pkg additions:
  - REG_STATUS = 1;
  - REG_CPU_RESET_MIN_NS = 1000;
  - REG_COUNT raised to 4;
  - typedef reg_state_t enum {IDLE, ACK}.
- REG_ADDR_WIDTH stays derived from REG_COUNT.
- One sub-module: reset_stretch, holding the counter and the registered cpu_reset_o. It is parameterised by CYCLES.

Test Plan:
1. Release reset_n_i at t0 → cpu_reset_o = 1 and cpu_ready_o = 0. Read REG_CPU → 0x02.
2. Write 0x01 to address {3'b010, 0} → cpu_reset_o stays 1 for exactly 64 cycles after the write edge, then 0. cpu_ready_o rises on the same cycle. Read → 0x01.
3. Write 0x03, then 0x01 on the next transaction, and 0x03 again at countdown 20 → countdown reloads; total reset = 64 cycles after the last 0x01 write.
4. Drive status_i = 0xA5, wait 3 cycles, read index 1 → 0xA5. Write 0xFF to index 1 → acked; a following read still returns 0xA5.
5. Write 0x5C to index 3 → ctrl_o[15:8] = 0x5C the cycle after accept. Write to index 7 → acked, and read of index 7 returns 0x00.
6. Strobe with prefix 3'b000 → no ack for 10 cycles. Assert reset_n_i low during ACK → ack deasserts immediately; state is IDLE after release.
